mlblock_sequencer: RTL and testbench
====================================

MLBLOCK_SEQUENCER -- requirements
Module: mlblock_sequencer

Interface
REQ-001 The block SHALL have parameter CFG_LEN, default 8: length of the MLBlock serial configuration chain in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of all cycle-count inputs.
REQ-003 The block SHALL have parameter DRAIN_CYC, default 3: MLBlock result-pipeline flush cycles; legal range 0..255.
REQ-004 The block SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1: job request, sampled in IDLE only.
REQ-007 The block SHALL have port abort, input, 1: synchronous job cancel.
REQ-008 The block SHALL have port cfg_word, input, CFG_LEN: configuration bits for the chain.
REQ-009 The block SHALL have port w_cycles, input, CNT_W: weight-load cycle count.
REQ-010 The block SHALL have port acc_len, input, CNT_W: cycles per accumulation window.
REQ-011 The block SHALL have port n_acc, input, CNT_W: number of accumulation windows.
REQ-012 The block SHALL have port config_en, output, 1: drives the MLBlock config_en input.
REQ-013 The block SHALL have port config_in, output, 1: drives the MLBlock config_in input.
REQ-014 The block SHALL have ports W_en, I_en and Res_en, each output, 1: drive the MLBlock enables of the same names.
REQ-015 The block SHALL have port Res_cas_in_zero, output, 1: clears the MLBlock cascade input at the start of each window.
REQ-016 The block SHALL have ports busy, done and err, each output, 1: job status.

Function
REQ-017 The state machine SHALL have states IDLE, CFG, WLOAD, COMP, DRAIN and DONE. All outputs SHALL be registered.
REQ-018 In IDLE, start=1 with acc_len!=0 and n_acc!=0 SHALL latch cfg_word, w_cycles, acc_len and n_acc, and SHALL move to CFG on the next cycle.
REQ-019 In IDLE, start=1 with acc_len==0 or n_acc==0 SHALL pulse err for exactly 1 cycle and SHALL remain in IDLE.
REQ-020 CFG SHALL last CFG_LEN cycles with config_en=1. On the k-th cycle (k=0..CFG_LEN-1), config_in SHALL equal latched cfg_word[CFG_LEN-1-k], so the MSB is shifted first.
REQ-021 WLOAD SHALL last w_cycles cycles with W_en=1. If w_cycles==0, WLOAD SHALL be skipped and the FSM SHALL go from CFG directly to COMP.
REQ-022 COMP SHALL last acc_len*n_acc cycles with I_en=1 and Res_en=1, using a window counter and a cycle counter; no multiplier is required.
REQ-023 Res_cas_in_zero SHALL be 1 on the first COMP cycle of each window and 0 on all other cycles.
REQ-024 DRAIN SHALL last DRAIN_CYC cycles with Res_en=1 and I_en=0. If DRAIN_CYC==0, DRAIN SHALL be skipped.
REQ-025 DONE SHALL last 1 cycle with done=1, then the FSM SHALL return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start SHALL be ignored while busy=1, and input changes while busy=1 SHALL NOT affect the running job.
REQ-028 At most one of config_en, W_en and I_en SHALL be 1 in any cycle.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with all strobes 0 and no done pulse.
REQ-030 abort=1 in IDLE SHALL have no effect. abort and start asserted together in IDLE SHALL start the job.
REQ-031 Counters SHALL be CNT_W wide. Counts up to 2^CNT_W-1 SHALL be exact, with no wrap-around before the terminal count.

Reset
REQ-032 While reset=1, the FSM SHALL be in IDLE, and all outputs (config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero, busy, done, err), all counters and all latched inputs SHALL be 0.
REQ-033 Reset asserted mid-job SHALL clear all outputs immediately (asynchronously), and the block SHALL NOT resume the job after reset release.
REQ-034 The first start SHALL be accepted on the first rising edge at which reset=0.

Verification
REQ-035 Nominal job: CFG_LEN=4, DRAIN_CYC=2, cfg_word=4'b1011, w_cycles=2, acc_len=3, n_acc=2, start pulsed once -> config_in sequence 1,0,1,1 with config_en high for 4 cycles; then W_en high for 2 cycles; then I_en high for 6 cycles with Res_cas_in_zero high on COMP cycles 0 and 3; then Res_en-only for 2 cycles; then done high for 1 cycle; busy high for 15 cycles total.
REQ-036 Skip phases: w_cycles=0, DRAIN_CYC=0, acc_len=1, n_acc=1 -> W_en never high; I_en and Res_cas_in_zero high for 1 cycle; done on the next cycle; busy high for CFG_LEN+2 cycles.
REQ-037 Error: start with n_acc=0 -> err high for 1 cycle, busy stays 0, and no strobe is asserted.
REQ-038 Abort: abort on the 3rd COMP cycle of the REQ-035 job -> all strobes 0 and busy 0 from the next cycle; done never asserted.
REQ-039 Reset mid-WLOAD: reset asserted between clock edges -> W_en and busy fall without waiting for a clock edge; a start after release runs a full job from CFG.
REQ-040 Start while busy: a second start during COMP, with changed cfg_word -> ignored; the running job completes unchanged; exactly one done pulse.

Source files
------------

// File: rtl/mlblock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mlblock_sequencer
// Brief    : Job sequencer driving an MLBlock through config shift, weight
//            load, windowed compute and result drain.
// Revision : 1.0 - initial release
// ============================================================================
module mlblock_sequencer #(
   parameter int CFG_LEN   = 8,
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [CFG_LEN-1:0] cfg_word,
   input  logic [CNT_W-1:0]   w_cycles,
   input  logic [CNT_W-1:0]   acc_len,
   input  logic [CNT_W-1:0]   n_acc,
   output logic               config_en,
   output logic               config_in,
   output logic               W_en,
   output logic               I_en,
   output logic               Res_en,
   output logic               Res_cas_in_zero,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_cfg   = 3'd1;
   localparam logic [2:0] c_wload = 3'd2;
   localparam logic [2:0] c_comp  = 3'd3;
   localparam logic [2:0] c_drain = 3'd4;
   localparam logic [2:0] c_done  = 3'd5;

   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cfg_last  = CNT_W'(CFG_LEN - 1);
   localparam logic [CNT_W-1:0] c_drain_last = CNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

   logic [2:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_win;
   logic [CFG_LEN-1:0] r_cfg;
   logic [CNT_W-1:0]   r_w_cycles;
   logic [CNT_W-1:0]   r_acc_len;
   logic [CNT_W-1:0]   r_n_acc;

   logic [2:0]         w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_win_nxt;
   logic               w_accept;
   logic               w_reject;

   logic w_config_en_nxt, w_config_in_nxt, w_w_en_nxt, w_i_en_nxt, w_res_en_nxt;
   logic w_cas_zero_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

   assign w_accept = (r_state == c_idle) && start && (acc_len != '0) && (n_acc != '0);
   assign w_reject = (r_state == c_idle) && start && ((acc_len == '0) || (n_acc == '0));

   // State register, counters, latched job parameters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= c_idle;
         r_cnt           <= '0;
         r_win           <= '0;
         r_cfg           <= '0;
         r_w_cycles      <= '0;
         r_acc_len       <= '0;
         r_n_acc         <= '0;
         config_en       <= 1'b0;
         config_in       <= 1'b0;
         W_en            <= 1'b0;
         I_en            <= 1'b0;
         Res_en          <= 1'b0;
         Res_cas_in_zero <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_win   <= w_win_nxt;
         if (w_accept) begin
            r_cfg      <= cfg_word << 1;
            r_w_cycles <= w_cycles;
            r_acc_len  <= acc_len;
            r_n_acc    <= n_acc;
         end else if (r_state == c_cfg) begin
            r_cfg <= r_cfg << 1;
         end
         config_en       <= w_config_en_nxt;
         config_in       <= w_config_in_nxt;
         W_en            <= w_w_en_nxt;
         I_en            <= w_i_en_nxt;
         Res_en          <= w_res_en_nxt;
         Res_cas_in_zero <= w_cas_zero_nxt;
         busy            <= w_busy_nxt;
         done            <= w_done_nxt;
         err             <= w_err_nxt;
      end
   end

   // r_cnt is the cycle index within the current phase (or window in COMP)
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_win_nxt   = r_win;
      case (r_state)
         c_idle: begin
            if (w_accept) begin
               w_state_nxt = c_cfg;
               w_cnt_nxt   = '0;
               w_win_nxt   = '0;
            end
         end
         c_cfg: begin
            if (r_cnt == c_cfg_last) begin
               w_state_nxt = (r_w_cycles != '0) ? c_wload : c_comp;
               w_cnt_nxt   = '0;
               w_win_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         c_wload: begin
            if (r_cnt == r_w_cycles - c_one) begin
               w_state_nxt = c_comp;
               w_cnt_nxt   = '0;
               w_win_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         c_comp: begin
            if (r_cnt == r_acc_len - c_one) begin
               w_cnt_nxt = '0;
               if (r_win == r_n_acc - c_one) begin
                  w_state_nxt = (DRAIN_CYC != 0) ? c_drain : c_done;
                  w_win_nxt   = '0;
               end else begin
                  w_win_nxt = r_win + c_one;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         c_drain: begin
            if (r_cnt == c_drain_last) begin
               w_state_nxt = c_done;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         c_done: begin
            w_state_nxt = c_idle;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = c_idle;
            w_cnt_nxt   = '0;
            w_win_nxt   = '0;
         end
      endcase
      if (abort && (r_state != c_idle)) begin
         w_state_nxt = c_idle;
         w_cnt_nxt   = '0;
         w_win_nxt   = '0;
      end
   end

   // Outputs are decoded from the upcoming state so they register in step with it
   always_comb begin
      w_config_en_nxt = (w_state_nxt == c_cfg);
      w_config_in_nxt = 1'b0;
      if (w_accept)
         w_config_in_nxt = cfg_word[CFG_LEN-1];
      else if ((r_state == c_cfg) && (w_state_nxt == c_cfg))
         w_config_in_nxt = r_cfg[CFG_LEN-1];
      w_w_en_nxt      = (w_state_nxt == c_wload);
      w_i_en_nxt      = (w_state_nxt == c_comp);
      w_res_en_nxt    = (w_state_nxt == c_comp) || (w_state_nxt == c_drain);
      w_cas_zero_nxt  = (w_state_nxt == c_comp) && (w_cnt_nxt == '0);
      w_busy_nxt      = (w_state_nxt != c_idle);
      w_done_nxt      = (w_state_nxt == c_done);
      w_err_nxt       = w_reject;
   end

endmodule
`default_nettype wire

// File: tb/tb_mlblock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlblock_sequencer
// Brief    : Directed self-checking bench; two instances cover DRAIN_CYC=2/0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlblock_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic [3:0]  cfg_word;
   logic [15:0] w_cycles, acc_len, n_acc;

   logic cen_a, cin_a, wen_a, ien_a, ren_a, cas_a, busy_a, done_a, err_a;
   logic cen_b, cin_b, wen_b, ien_b, ren_b, cas_b, busy_b, done_b, err_b;

   // {busy, done, err, config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero}
   logic [8:0] vec_a, vec_b;
   assign vec_a = {busy_a, done_a, err_a, cen_a, cin_a, wen_a, ien_a, ren_a, cas_a};
   assign vec_b = {busy_b, done_b, err_b, cen_b, cin_b, wen_b, ien_b, ren_b, cas_b};

   logic [8:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   mlblock_sequencer #(.CFG_LEN(4), .CNT_W(16), .DRAIN_CYC(2)) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_word(cfg_word),
      .w_cycles(w_cycles), .acc_len(acc_len), .n_acc(n_acc),
      .config_en(cen_a), .config_in(cin_a), .W_en(wen_a), .I_en(ien_a), .Res_en(ren_a),
      .Res_cas_in_zero(cas_a), .busy(busy_a), .done(done_a), .err(err_a)
   );

   mlblock_sequencer #(.CFG_LEN(4), .CNT_W(16), .DRAIN_CYC(0)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_word(cfg_word),
      .w_cycles(w_cycles), .acc_len(acc_len), .n_acc(n_acc),
      .config_en(cen_b), .config_in(cin_b), .W_en(wen_b), .I_en(ien_b), .Res_en(ren_b),
      .Res_cas_in_zero(cas_b), .busy(busy_b), .done(done_b), .err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got[8:0], exp[8:0]);
      end
   endtask

   task automatic setup(input logic [3:0] cw, input logic [15:0] w, input logic [15:0] a,
                        input logic [15:0] n);
      cfg_word = cw;
      w_cycles = w;
      acc_len  = a;
      n_acc    = n;
      start    = 1'b1;
   endtask

   // cfg 1011, w=2, acc=3, n=2 on the DRAIN_CYC=2 instance
   task automatic load_nominal();
      exp_q = '{9'b100110000, 9'b100100000, 9'b100110000, 9'b100110000,
                9'b100001000, 9'b100001000,
                9'b100000111, 9'b100000110, 9'b100000110,
                9'b100000111, 9'b100000110, 9'b100000110,
                9'b100000010, 9'b100000010,
                9'b110000000, 9'b000000000};
   endtask

   task automatic run_job(input string tag, input bit sel_b, input int abort_at,
                          input int restart_at);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         abort = 1'b0;
         check($sformatf("%s[%0d]", tag, i), sel_b ? vec_b : vec_a, exp_q[i]);
         if (i == abort_at) abort = 1'b1;
         if (i == restart_at) begin
            start    = 1'b1;
            cfg_word = 4'b0100;
            w_cycles = 16'd5;
            acc_len  = 16'd7;
            n_acc    = 16'd9;
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_word = '0; w_cycles = '0; acc_len = '0; n_acc = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", vec_a, 9'b0);
      check("reset_b", vec_b, 9'b0);

      // Start presented together with reset release
      @(negedge clk);
      reset = 1'b0;
      setup(4'b1011, 16'd2, 16'd3, 16'd2);
      load_nominal();
      run_job("nominal", 1'b0, -1, -1);
      repeat (3) @(posedge clk);

      // Skip phases on the no-drain instance
      @(negedge clk);
      setup(4'b0110, 16'd0, 16'd1, 16'd1);
      exp_q = '{9'b100100000, 9'b100110000, 9'b100110000, 9'b100100000,
                9'b100000111, 9'b110000000, 9'b000000000};
      run_job("skip_b", 1'b1, -1, -1);
      repeat (4) @(posedge clk);

      // Single-cycle windows: Res_cas_in_zero every compute cycle
      @(negedge clk);
      setup(4'b0000, 16'd1, 16'd1, 16'd3);
      exp_q = '{9'b100100000, 9'b100100000, 9'b100100000, 9'b100100000,
                9'b100001000, 9'b100000111, 9'b100000111, 9'b100000111,
                9'b110000000, 9'b000000000};
      run_job("win1_b", 1'b1, -1, -1);
      repeat (4) @(posedge clk);

      // Rejected jobs
      @(negedge clk);
      setup(4'b1111, 16'd2, 16'd3, 16'd0);
      exp_q = '{9'b001000000, 9'b000000000, 9'b000000000};
      run_job("err_nacc", 1'b0, -1, -1);
      @(negedge clk);
      setup(4'b1111, 16'd2, 16'd0, 16'd4);
      run_job("err_acc_b", 1'b1, -1, -1);

      // Abort on the third compute cycle
      @(negedge clk);
      setup(4'b1011, 16'd2, 16'd3, 16'd2);
      load_nominal();
      exp_q = exp_q[0:8];
      for (int k = 0; k < 4; k++) exp_q.push_back(9'b0);
      run_job("abort", 1'b0, 8, -1);
      repeat (3) @(posedge clk);

      // Abort together with start in IDLE still launches the job
      @(negedge clk);
      setup(4'b1011, 16'd2, 16'd3, 16'd2);
      abort = 1'b1;
      load_nominal();
      run_job("abort_start", 1'b0, -1, -1);
      repeat (3) @(posedge clk);

      // Second start with different parameters mid-compute is ignored
      @(negedge clk);
      setup(4'b1011, 16'd2, 16'd3, 16'd2);
      load_nominal();
      run_job("busy_start", 1'b0, -1, 7);
      repeat (3) @(posedge clk);

      // Asynchronous reset during weight load
      @(negedge clk);
      setup(4'b1011, 16'd2, 16'd3, 16'd2);
      load_nominal();
      exp_q = exp_q[0:4];
      run_job("pre_rst", 1'b0, -1, -1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_a", vec_a, 9'b0);
      check("rst_async_b", vec_b, 9'b0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q = '{9'b0, 9'b0, 9'b0};
      run_job("no_resume", 1'b0, -1, -1);
      @(negedge clk);
      setup(4'b1011, 16'd2, 16'd3, 16'd2);
      load_nominal();
      run_job("post_rst", 1'b0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
